axi4_sub_mem: RTL

AXI4 subordinate memory that sits directly downstream of `axi4_mgr` on an `axi4_bus_if` link and services its write and read bursts. Independent write (AW/W/B) and read (AR/R) FSMs share one word-addressed storage array with one write port and one read port. Used as the bench and FPGA-side target for manager bring-up.

---
 rtl/axi4_sub_mem_if.sv | 77 +++++++
 rtl/axi4_sub_mem.sv | 138 +++++++++++++
 2 files changed

// File: rtl/axi4_sub_mem_if.sv
// axi4_bus_if: AXI4 link between a manager and a subordinate, with Manager and Subordinate modports.
interface axi4_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int USER_W = 1
);
  logic [ID_W-1:0]     aw_id;
  logic [ADDR_W-1:0]   aw_addr;
  logic [7:0]          aw_len;
  logic [2:0]          aw_size;
  logic [1:0]          aw_burst;
  logic                aw_lock;
  logic [3:0]          aw_cache;
  logic [2:0]          aw_prot;
  logic [3:0]          aw_qos;
  logic [3:0]          aw_region;
  logic [5:0]          aw_atop;
  logic [USER_W-1:0]   aw_user;
  logic                aw_valid;
  logic                aw_ready;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;
  logic [USER_W-1:0]   w_user;
  logic                w_valid;
  logic                w_ready;
  logic [ID_W-1:0]     b_id;
  logic [1:0]          b_resp;
  logic [USER_W-1:0]   b_user;
  logic                b_valid;
  logic                b_ready;
  logic [ID_W-1:0]     ar_id;
  logic [ADDR_W-1:0]   ar_addr;
  logic [7:0]          ar_len;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;
  logic                ar_lock;
  logic [3:0]          ar_cache;
  logic [2:0]          ar_prot;
  logic [3:0]          ar_qos;
  logic [3:0]          ar_region;
  logic [USER_W-1:0]   ar_user;
  logic                ar_valid;
  logic                ar_ready;
  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_last;
  logic [USER_W-1:0]   r_user;
  logic                r_valid;
  logic                r_ready;
  modport Manager (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );
  modport Subordinate (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi4_sub_mem.sv
// axi4_sub_mem: AXI4 subordinate memory with independent write (AW/W/B) and read (AR/R) FSMs.
// Ports: clk_i (clock), rst_i (sync active-high reset), axi_sub_if (axi4_bus_if.Subordinate).
// Define AXI4_SUB_MEM_ERR_EN to flag out-of-range beats with SLVERR instead of aliasing.
module axi4_sub_mem #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_ID_WIDTH    = 4,
  parameter int MEM_DEPTH_WORDS = 1024
) (
  input logic             clk_i,
  input logic             rst_i,
  axi4_bus_if.Subordinate axi_sub_if
);
  localparam int BPB = AXI_DATA_WIDTH / 8;
  localparam int OFF = $clog2(BPB);
  localparam int IW  = $clog2(MEM_DEPTH_WORDS);
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_DATA} rd_state_t;
  wr_state_t                 r_wst;
  rd_state_t                 r_rst;
  logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_DEPTH_WORDS];
  logic [AXI_ADDR_WIDTH-1:0] r_waddr, r_raddr;
  logic [7:0]                r_wlen, r_rlen, r_wcnt, r_rcnt;
  logic                      r_wfix, r_rfix, r_werr;
  logic                      w_wbeat, w_wend, w_wmis, w_woob, w_roob;
  logic [IW-1:0]             w_widx, w_ridx;
  assign w_widx  = r_waddr[OFF +: IW];
  assign w_ridx  = r_raddr[OFF +: IW];
  assign w_wbeat = (r_wst == WR_DATA) && axi_sub_if.w_valid && axi_sub_if.w_ready;
  assign w_wend  = r_wcnt == r_wlen;
  // The beat count, not w_last, ends the burst; a disagreeing w_last only flags an error.
  assign w_wmis  = axi_sub_if.w_last != w_wend;
`ifdef AXI4_SUB_MEM_ERR_EN
  assign w_woob = r_waddr >= AXI_ADDR_WIDTH'(MEM_DEPTH_WORDS * BPB);
  assign w_roob = r_raddr >= AXI_ADDR_WIDTH'(MEM_DEPTH_WORDS * BPB);
`else
  assign w_woob = 1'b0;
  assign w_roob = 1'b0;
`endif
  assign axi_sub_if.b_user = '0;
  assign axi_sub_if.r_user = '0;
  always_ff @(posedge clk_i)
    if (w_wbeat && !w_woob)
      for (int i = 0; i < BPB; i++)
        if (axi_sub_if.w_strb[i]) r_mem[w_widx][i*8 +: 8] <= axi_sub_if.w_data[i*8 +: 8];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wst               <= WR_IDLE;
      r_werr              <= 1'b0;
      axi_sub_if.aw_ready <= 1'b0;
      axi_sub_if.w_ready  <= 1'b0;
      axi_sub_if.b_valid  <= 1'b0;
      axi_sub_if.b_resp   <= 2'b00;
      axi_sub_if.b_id     <= '0;
    end else begin
      case (r_wst)
        WR_IDLE: begin
          axi_sub_if.aw_ready <= 1'b1;
          if (axi_sub_if.aw_valid && axi_sub_if.aw_ready) begin
            axi_sub_if.aw_ready <= 1'b0;
            axi_sub_if.w_ready  <= 1'b1;
            axi_sub_if.b_id     <= AXI_ID_WIDTH'(axi_sub_if.aw_id);
            r_waddr             <= axi_sub_if.aw_addr;
            r_wlen              <= axi_sub_if.aw_len;
            r_wfix              <= axi_sub_if.aw_burst == 2'b00;
            r_wcnt              <= 8'd0;
            r_werr              <= 1'b0;
            r_wst               <= WR_DATA;
          end
        end
        WR_DATA:
          if (w_wbeat) begin
            r_waddr <= r_wfix ? r_waddr : r_waddr + AXI_ADDR_WIDTH'(BPB);
            r_wcnt  <= r_wcnt + 8'd1;
            r_werr  <= r_werr | w_wmis | w_woob;
            if (w_wend) begin
              axi_sub_if.w_ready <= 1'b0;
              axi_sub_if.b_valid <= 1'b1;
              axi_sub_if.b_resp  <= (r_werr | w_wmis | w_woob) ? 2'b10 : 2'b00;
              r_wst              <= WR_RESP;
            end
          end
        WR_RESP:
          if (axi_sub_if.b_ready) begin
            axi_sub_if.b_valid <= 1'b0;
            r_wst              <= WR_IDLE;
          end
        default: r_wst <= WR_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rst               <= RD_IDLE;
      axi_sub_if.ar_ready <= 1'b0;
      axi_sub_if.r_valid  <= 1'b0;
      axi_sub_if.r_last   <= 1'b0;
      axi_sub_if.r_resp   <= 2'b00;
      axi_sub_if.r_data   <= '0;
      axi_sub_if.r_id     <= '0;
    end else begin
      case (r_rst)
        RD_IDLE: begin
          axi_sub_if.ar_ready <= 1'b1;
          if (axi_sub_if.ar_valid && axi_sub_if.ar_ready) begin
            axi_sub_if.ar_ready <= 1'b0;
            axi_sub_if.r_id     <= AXI_ID_WIDTH'(axi_sub_if.ar_id);
            r_raddr             <= axi_sub_if.ar_addr;
            r_rlen              <= axi_sub_if.ar_len;
            r_rfix              <= axi_sub_if.ar_burst == 2'b00;
            r_rcnt              <= 8'd0;
            r_rst               <= RD_FETCH;
          end
        end
        RD_FETCH: begin
          // Non-blocking read of the array gives read-before-write against a same-cycle write.
          axi_sub_if.r_data  <= w_roob ? '0 : r_mem[w_ridx];
          axi_sub_if.r_resp  <= w_roob ? 2'b10 : 2'b00;
          axi_sub_if.r_last  <= r_rcnt == r_rlen;
          axi_sub_if.r_valid <= 1'b1;
          r_rst              <= RD_DATA;
        end
        RD_DATA:
          if (axi_sub_if.r_ready) begin
            axi_sub_if.r_valid <= 1'b0;
            axi_sub_if.r_last  <= 1'b0;
            if (axi_sub_if.r_last) r_rst <= RD_IDLE;
            else begin
              r_raddr <= r_rfix ? r_raddr : r_raddr + AXI_ADDR_WIDTH'(BPB);
              r_rcnt  <= r_rcnt + 8'd1;
              r_rst   <= RD_FETCH;
            end
          end
        default: r_rst <= RD_IDLE;
      endcase
    end
  end
endmodule
